// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
//
// Purpose:
//   Buffers the write-back commit trace of the CPU core for an off-core
//   consumer (trace comparator, UART dumper, logic analyser). Each retired
//   register-writing instruction is captured as a record {pc, rd, data} and
//   presented one at a time on a first-word-fall-through output port. The
//   core is never stalled: commits that arrive while the buffer is full are
//   discarded, counted in drop_cnt and flagged by the sticky overflow bit.
//
// Parameters:
//   DEPTH     number of record slots, power of 2, minimum 2
//   AW        pointer width, log2(DEPTH)
//   FILTER_X0 1: commits to x0 (rd==0) are not captured; 0: they are
//
// Ports:
//   clk           core clock
//   reset         synchronous, active-low reset
//   wb_have_inst  WB stage holds a valid retired instruction this cycle
//   wb_pc         PC of the WB instruction
//   wb_rf_WE      WB instruction writes the register file
//   wb_RD         destination register index
//   wb_data       write-back value
//   out_valid     head record available
//   out_ready     consumer accepts head record
//   out_pc        head record PC
//   out_rd        head record rd
//   out_data      head record data
//   count         records currently stored, 0..DEPTH
//   full          count == DEPTH
//   overflow      sticky; one or more records were dropped
//   drop_cnt      dropped-record counter, saturates at 16'hFFFF
//   clr_ovf       synchronous clear of overflow and drop_cnt
//
// Handshake (output port): a record transfers on every rising edge where
// out_valid and out_ready are both 1. out_valid does not depend on out_ready,
// and while out_valid is 1 the head record stays stable until it is taken.
// out_ready may be high while out_valid is low; nothing transfers then.
// -----------------------------------------------------------------------------
module wb_trace_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_have_inst,
  input  logic [31:0]   wb_pc,
  input  logic          wb_rf_WE,
  input  logic [4:0]    wb_RD,
  input  logic [31:0]   wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_rd,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  input  logic          clr_ovf
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [15:0] DROP_MAX   = 16'hFFFF;

  // Record storage; contents are don't-care until written, so not reset.
  rec_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [15:0]   drop_cnt_q;

  logic cap;
  logic pop;
  logic push;
  logic drop;
  logic is_full;
  logic is_empty;
  rec_t wb_rec;
  rec_t head;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    is_full  = (count_q == FULL_COUNT);
    is_empty = (count_q == '0);
    cap      = wb_have_inst & wb_rf_WE & ((FILTER_X0 == 1'b0) | (wb_RD != 5'd0));
    pop      = ~is_empty & out_ready;
    // A pop in the same cycle frees the head slot, so a full buffer can still
    // take the new record: wr_ptr == rd_ptr then, and the read of the old head
    // and the write of the new record hit the same slot on the same edge.
    push     = cap & (~is_full | pop);
    drop     = cap & is_full & ~pop;
    wb_rec   = {wb_pc, wb_RD, wb_data};
  end

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= wb_rec;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy. Pointers wrap naturally at DEPTH; count tells a
  // full buffer apart from an empty one when the pointers are equal.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loss accounting. A clear that coincides with a drop must not lose that
  // drop, so the result is "one record lost" rather than zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through output: the head slot is shown directly, forced to
  // zero when the buffer is empty so stale slots never leak out.
  // ---------------------------------------------------------------------------
  always_comb begin
    head      = mem[rd_ptr];
    out_valid = ~is_empty;
    if (is_empty) begin
      out_pc   = '0;
      out_rd   = '0;
      out_data = '0;
    end else begin
      out_pc   = head.pc;
      out_rd   = head.rd;
      out_data = head.data;
    end
    count    = count_q;
    full     = is_full;
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_fifo
//
// Drives two instances of wb_trace_fifo from the same stimulus: dut0 with
// FILTER_X0=1 and dut1 with FILTER_X0=0. A queue-based reference model of
// each buffer (exp_q / exp_q1 plus loss counters) predicts the outputs after
// every clock edge. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 69;   // {pc[31:0], rd[4:0], data[31:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        = 1'b0;
  logic        wb_have_inst = 1'b0;
  logic [31:0] wb_pc        = '0;
  logic        wb_rf_WE     = 1'b0;
  logic [4:0]  wb_RD        = '0;
  logic [31:0] wb_data      = '0;
  logic        out_ready    = 1'b0;
  logic        clr_ovf      = 1'b0;

  logic        out_valid0, out_valid1;
  logic [31:0] out_pc0, out_pc1;
  logic [4:0]  out_rd0, out_rd1;
  logic [31:0] out_data0, out_data1;
  logic [AW:0] count0, count1;
  logic        full0, full1;
  logic        overflow0, overflow1;
  logic [15:0] drop_cnt0, drop_cnt1;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .FILTER_X0(1'b1)) dut0 (
    .clk(clk), .reset(reset), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_rf_WE(wb_rf_WE), .wb_RD(wb_RD), .wb_data(wb_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0),
    .out_rd(out_rd0), .out_data(out_data0), .count(count0), .full(full0),
    .overflow(overflow0), .drop_cnt(drop_cnt0), .clr_ovf(clr_ovf)
  );

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .FILTER_X0(1'b0)) dut1 (
    .clk(clk), .reset(reset), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_rf_WE(wb_rf_WE), .wb_RD(wb_RD), .wb_data(wb_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1),
    .out_rd(out_rd1), .out_data(out_data1), .count(count1), .full(full1),
    .overflow(overflow1), .drop_cnt(drop_cnt1), .clr_ovf(clr_ovf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: reference model state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];    // model of dut0 (rd==0 filtered)
  logic [W-1:0] exp_q1[$];   // model of dut1 (rd==0 captured)
  logic         exp_ovf[2];
  int           exp_drops[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one model by one clock edge given the inputs applied before it.
  task automatic model_edge(input int k, input logic rst_n, input logic have,
                            input logic we, input logic [4:0] rd,
                            input logic [W-1:0] rec, input logic rdy,
                            input logic clr);
    int  sz;
    bit  cap, pop, accept, lost;
    if (!rst_n) begin
      if (k == 0) exp_q.delete(); else exp_q1.delete();
      exp_ovf[k]   = 1'b0;
      exp_drops[k] = 0;
      return;
    end
    sz     = (k == 0) ? exp_q.size() : exp_q1.size();
    cap    = have && we && (k == 1 || rd != 5'd0);
    pop    = (sz > 0) && rdy;
    accept = cap && (sz < DEPTH || pop);
    lost   = cap && !accept;
    if (k == 0) begin
      if (pop) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(rec);
    end else begin
      if (pop) void'(exp_q1.pop_front());
      if (accept) exp_q1.push_back(rec);
    end
    if (lost) begin
      exp_ovf[k]   = 1'b1;
      exp_drops[k] = clr ? 1 : ((exp_drops[k] < 65535) ? exp_drops[k] + 1 : 65535);
    end else if (clr) begin
      exp_ovf[k]   = 1'b0;
      exp_drops[k] = 0;
    end
  endtask

  task automatic check_dut(input string pfx, input int k, input logic v,
                           input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] data, input logic [AW:0] cnt,
                           input logic fl, input logic ovf, input logic [15:0] dc);
    logic [W-1:0] head;
    int sz;
    sz   = (k == 0) ? exp_q.size() : exp_q1.size();
    head = '0;
    if (sz > 0) head = (k == 0) ? exp_q[0] : exp_q1[0];
    check_eq({pfx, "_valid"}, 64'(v), 64'(sz > 0));
    check_eq({pfx, "_pc"}, 64'(pc), 64'(head[68:37]));
    check_eq({pfx, "_rd"}, 64'(rd), 64'(head[36:32]));
    check_eq({pfx, "_data"}, 64'(data), 64'(head[31:0]));
    check_eq({pfx, "_count"}, 64'(cnt), 64'(sz));
    check_eq({pfx, "_full"}, 64'(fl), 64'(sz == DEPTH));
    check_eq({pfx, "_overflow"}, 64'(ovf), 64'(exp_ovf[k]));
    check_eq({pfx, "_drop_cnt"}, 64'(dc), 64'(exp_drops[k]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: applies inputs just after an edge, updates the models, lets the
  // next edge happen and compares both DUTs 1 time unit later.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst_n, input logic have, input logic we,
                       input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] data, input logic rdy, input logic clr);
    reset        = rst_n;
    wb_have_inst = have;
    wb_rf_WE     = we;
    wb_pc        = pc;
    wb_RD        = rd;
    wb_data      = data;
    out_ready    = rdy;
    clr_ovf      = clr;
    model_edge(0, rst_n, have, we, rd, {pc, rd, data}, rdy, clr);
    model_edge(1, rst_n, have, we, rd, {pc, rd, data}, rdy, clr);
    @(posedge clk);
    #1;
    check_dut("d0", 0, out_valid0, out_pc0, out_rd0, out_data0, count0, full0, overflow0, drop_cnt0);
    check_dut("d1", 1, out_valid1, out_pc1, out_rd1, out_data1, count1, full1, overflow1, drop_cnt1);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, rdy, 1'b0);
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic rdy, input logic clr);
    drive(1'b1, 1'b1, 1'b1, pc, rd, data, rdy, clr);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] next_pc;
    logic [31:0] last_pc;

    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    check_eq("rst_count", 64'(count0), 64'd0);
    check_eq("rst_valid", 64'(out_valid0), 64'd0);

    // Single commit with consumer stalled
    commit(32'h0000_0004, 5'd5, 32'h0000_002A, 1'b0, 1'b0);
    check_eq("first_valid", 64'(out_valid0), 64'd1);
    check_eq("first_pc", 64'(out_pc0), 64'h4);
    check_eq("first_rd", 64'(out_rd0), 64'd5);
    check_eq("first_data", 64'(out_data0), 64'h2A);
    check_eq("first_count", 64'(count0), 64'd1);
    idle(1'b1);
    idle(1'b1);   // empty with out_ready=1: nothing moves

    // Filtering: rd==0 commit and a non-writing instruction
    commit(32'h0000_0100, 5'd0, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0104, 5'd3, 32'h2222_2222, 1'b0, 1'b0);
    check_eq("filt_count_x0", 64'(count0), 64'd0);
    check_eq("nofilt_count_x0", 64'(count1), 64'd1);
    check_eq("nofilt_rd", 64'(out_rd1), 64'd0);
    idle(1'b1);
    idle(1'b1);

    // 18 commits into a 16-deep buffer with the consumer stalled
    for (int i = 0; i < 18; i++) begin
      commit(32'(i * 4), 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0);
    end
    check_eq("fill_count", 64'(count0), 64'd16);
    check_eq("fill_full", 64'(full0), 64'd1);
    check_eq("fill_overflow", 64'(overflow0), 64'd1);
    check_eq("fill_drop_cnt", 64'(drop_cnt0), 64'd2);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_pc", 64'(out_pc0), 64'(i * 4));
      idle(1'b1);
    end
    check_eq("drain_valid", 64'(out_valid0), 64'd0);

    // Refill, then push and pop together every cycle while full
    next_pc = 32'h0000_1000;
    for (int i = 0; i < 16; i++) begin
      commit(next_pc, 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0);
      next_pc += 4;
    end
    last_pc = 32'h0000_0FFC;
    for (int i = 0; i < 20; i++) begin
      check_eq("steady_inc", 64'(out_pc0 > last_pc), 64'd1);
      last_pc = out_pc0;
      commit(next_pc, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0);
      next_pc += 4;
      check_eq("steady_count", 64'(count0), 64'd16);
    end
    check_eq("steady_drop_cnt", 64'(drop_cnt0), 64'd2);

    // Overflow clear, without and with a coincident drop
    commit(next_pc, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
    next_pc += 4;
    check_eq("ovf_drop3", 64'(drop_cnt0), 64'd3);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("clr_overflow", 64'(overflow0), 64'd0);
    check_eq("clr_drop_cnt", 64'(drop_cnt0), 64'd0);
    commit(next_pc, 5'd7, 32'hCAFE_F00D, 1'b0, 1'b1);
    next_pc += 4;
    check_eq("clr_drop_overflow", 64'(overflow0), 64'd1);
    check_eq("clr_drop_drop_cnt", 64'(drop_cnt0), 64'd1);
    check_eq("clr_keeps_count", 64'(count0), 64'd16);

    // Reset mid-operation with push and pop active
    for (int i = 0; i < 9; i++) idle(1'b1);
    check_eq("pre_rst_count", 64'(count0), 64'd7);
    drive(1'b0, 1'b1, 1'b1, next_pc, 5'd9, 32'h1234_5678, 1'b1, 1'b0);
    check_eq("midrst_count", 64'(count0), 64'd0);
    check_eq("midrst_valid", 64'(out_valid0), 64'd0);
    check_eq("midrst_pc", 64'(out_pc0), 64'd0);
    check_eq("midrst_overflow", 64'(overflow0), 64'd0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) != 0),
            $urandom, 5'($urandom_range(0, 3)), $urandom,
            ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
